// File: rtl/polygon_pkg.sv
// Shared types and constants for the polygon vertex loader and the fill stage.
package polygon_pkg;

  localparam int DEFAULT_MAX_NUM_VERTICES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    PENDING = 2'd3
  } state_e;

endpackage

// File: rtl/vertex_transform.sv
// World-to-screen transform: (w - cam) * PIXEL_SCALE in wrapping signed 32-bit arithmetic.
module vertex_transform #(
  parameter int PIXEL_SCALE = 1
) (
  input  logic signed [31:0] x_i,
  input  logic signed [31:0] y_i,
  input  logic signed [31:0] cam_x_i,
  input  logic signed [31:0] cam_y_i,
  output logic signed [31:0] sx_o,
  output logic signed [31:0] sy_o
);

  localparam logic signed [31:0] SCALE = 32'(PIXEL_SCALE);

  // Both the subtraction and the product keep only the low 32 bits; overflow wraps.
  function automatic logic signed [31:0] to_screen(input logic signed [31:0] w,
                                                   input logic signed [31:0] c);
    logic signed [31:0] d;
    d = w - c;
    return d * SCALE;
  endfunction

  assign sx_o = to_screen(x_i, cam_x_i);
  assign sy_o = to_screen(y_i, cam_y_i);

endmodule

// File: rtl/polygon_vertex_loader.sv
// Collects a polygon's vertices into a write buffer and presents it to the fill stage at a frame boundary.
module polygon_vertex_loader
  import polygon_pkg::*;
#(
  parameter int MAX_NUM_VERTICES = DEFAULT_MAX_NUM_VERTICES,
  parameter int PIXEL_SCALE      = 1
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic                                frame_start_in,
  input  logic [31:0]                         camera_x_in,
  input  logic [31:0]                         camera_y_in,
  input  logic                                vertex_valid_in,
  output logic                                vertex_ready_out,
  input  logic signed [31:0]                  vertex_x_in,
  input  logic signed [31:0]                  vertex_y_in,
  input  logic                                vertex_last_in,
  output logic signed [31:0]                  xs_out [MAX_NUM_VERTICES],
  output logic signed [31:0]                  ys_out [MAX_NUM_VERTICES],
  output logic [$clog2(MAX_NUM_VERTICES):0]   num_points_out,
  output logic                                polygon_valid_out,
  output logic                                error_out
);

  localparam int CW = $clog2(MAX_NUM_VERTICES) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic signed [31:0] cam_x_q, cam_x_d, cam_y_q, cam_y_d;
  logic signed [31:0] wx_q [MAX_NUM_VERTICES];
  logic signed [31:0] wx_d [MAX_NUM_VERTICES];
  logic signed [31:0] wy_q [MAX_NUM_VERTICES];
  logic signed [31:0] wy_d [MAX_NUM_VERTICES];
  logic signed [31:0] ox_q [MAX_NUM_VERTICES];
  logic signed [31:0] ox_d [MAX_NUM_VERTICES];
  logic signed [31:0] oy_q [MAX_NUM_VERTICES];
  logic signed [31:0] oy_d [MAX_NUM_VERTICES];
  logic [CW-1:0]      np_q, np_d;
  logic               pv_q, pv_d;
  logic               err_q, err_d;

  logic               accept;
  logic signed [31:0] cam_x_sel, cam_y_sel;
  logic signed [31:0] sx, sy;

  assign vertex_ready_out = !rst_in && (state_q != PENDING);
  assign accept           = vertex_valid_in && vertex_ready_out;

  // The first vertex is transformed with the live camera, later ones with the captured copy.
  assign cam_x_sel = (state_q == IDLE) ? $signed(camera_x_in) : cam_x_q;
  assign cam_y_sel = (state_q == IDLE) ? $signed(camera_y_in) : cam_y_q;

  vertex_transform #(
    .PIXEL_SCALE(PIXEL_SCALE)
  ) u_transform (
    .x_i     (vertex_x_in),
    .y_i     (vertex_y_in),
    .cam_x_i (cam_x_sel),
    .cam_y_i (cam_y_sel),
    .sx_o    (sx),
    .sy_o    (sy)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cam_x_d = cam_x_q;
    cam_y_d = cam_y_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    np_d    = np_q;
    pv_d    = pv_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cam_x_d = $signed(camera_x_in);
          cam_y_d = $signed(camera_y_in);
          wx_d[0] = sx;
          wy_d[0] = sy;
          if (vertex_last_in) begin
            err_d   = 1'b1;
            count_d = '0;
          end else begin
            count_d = CW'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (count_q == CW'(MAX_NUM_VERTICES)) begin
            err_d   = 1'b1;
            count_d = '0;
            state_d = vertex_last_in ? IDLE : DRAIN;
          end else begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
              if (count_q == CW'(i)) begin
                wx_d[i] = sx;
                wy_d[i] = sy;
              end
            end
            count_d = count_q + CW'(1);
            // count_q >= 2 here means this last beat makes at least three vertices.
            if (vertex_last_in) begin
              if (count_q >= CW'(2)) begin
                state_d = PENDING;
              end else begin
                err_d   = 1'b1;
                count_d = '0;
                state_d = IDLE;
              end
            end
          end
        end
      end
      DRAIN: begin
        if (accept && vertex_last_in) begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (frame_start_in) begin
          for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            ox_d[i] = (CW'(i) < count_q) ? wx_q[i] : '0;
            oy_d[i] = (CW'(i) < count_q) ? wy_q[i] : '0;
          end
          np_d    = count_q;
          pv_d    = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      count_q <= '0;
      cam_x_q <= '0;
      cam_y_q <= '0;
      np_q    <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
        wx_q[i] <= '0;
        wy_q[i] <= '0;
        ox_q[i] <= '0;
        oy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cam_x_q <= cam_x_d;
      cam_y_q <= cam_y_d;
      np_q    <= np_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  assign xs_out            = ox_q;
  assign ys_out            = oy_q;
  assign num_points_out    = np_q;
  assign polygon_valid_out = pv_q;
  assign error_out         = err_q;

endmodule

// File: tb/tb_polygon_vertex_loader.sv
// Scoreboard bench: stimulus queues expected output snapshots and error pulses; monitors compare on change.
module tb_polygon_vertex_loader;

  typedef struct packed {
    logic [3:0][31:0] xs;
    logic [3:0][31:0] ys;
    logic [2:0]       np;
    logic             pv;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: PIXEL_SCALE = 1
  logic               fsA = 0, vldA = 0, lastA = 0, rdyA, pvA, errA;
  logic [31:0]        cxA = 0, cyA = 0;
  logic signed [31:0] vxA = 0, vyA = 0;
  logic signed [31:0] xsA [4];
  logic signed [31:0] ysA [4];
  logic [2:0]         npA;

  // DUT B: PIXEL_SCALE = 2
  logic               fsB = 0, vldB = 0, lastB = 0, rdyB, pvB, errB;
  logic [31:0]        cxB = 0, cyB = 0;
  logic signed [31:0] vxB = 0, vyB = 0;
  logic signed [31:0] xsB [4];
  logic signed [31:0] ysB [4];
  logic [2:0]         npB;

  polygon_vertex_loader #(.MAX_NUM_VERTICES(4), .PIXEL_SCALE(1)) dut_a (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fsA),
    .camera_x_in(cxA), .camera_y_in(cyA),
    .vertex_valid_in(vldA), .vertex_ready_out(rdyA),
    .vertex_x_in(vxA), .vertex_y_in(vyA), .vertex_last_in(lastA),
    .xs_out(xsA), .ys_out(ysA), .num_points_out(npA),
    .polygon_valid_out(pvA), .error_out(errA)
  );

  polygon_vertex_loader #(.MAX_NUM_VERTICES(4), .PIXEL_SCALE(2)) dut_b (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fsB),
    .camera_x_in(cxB), .camera_y_in(cyB),
    .vertex_valid_in(vldB), .vertex_ready_out(rdyB),
    .vertex_x_in(vxB), .vertex_y_in(vyB), .vertex_last_in(lastB),
    .xs_out(xsB), .ys_out(ysB), .num_points_out(npB),
    .polygon_valid_out(pvB), .error_out(errB)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t qA[$];
  rec_t qB[$];
  int   qeA[$];
  int   qeB[$];
  bit   mon_en = 0;
  rec_t prevA, prevB;

  function automatic rec_t mk(input int np, input int x0, input int x1, input int x2, input int x3,
                              input int y0, input int y1, input int y2, input int y3);
    rec_t r;
    r.xs = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
    r.ys = {32'(y3), 32'(y2), 32'(y1), 32'(y0)};
    r.np = 3'(np);
    r.pv = (np != 0);
    return r;
  endfunction

  function automatic rec_t snap(input bit b);
    rec_t r;
    for (int i = 0; i < 4; i++) begin
      r.xs[i] = b ? xsB[i] : xsA[i];
      r.ys[i] = b ? ysB[i] : ysA[i];
    end
    r.np = b ? npB : npA;
    r.pv = b ? pvB : pvA;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic chk_rec(input string name, input rec_t got, input rec_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Output monitors: any change of the displayed polygon must match the next queued snapshot.
  always @(negedge clk) begin
    if (mon_en) begin
      rec_t cur;
      cur = snap(1'b0);
      if (cur !== prevA) begin
        if (qA.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL swap_A: outputs changed to %h, required no change", cur);
        end else chk_rec("swap_A", cur, qA.pop_front());
        prevA = cur;
      end
      if (errA === 1'b1) begin
        n_cmp++;
        if (qeA.size() == 0) begin
          n_bad++;
          $display("FAIL error_A: got pulse, required none");
        end else void'(qeA.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      rec_t cur;
      cur = snap(1'b1);
      if (cur !== prevB) begin
        if (qB.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL swap_B: outputs changed to %h, required no change", cur);
        end else chk_rec("swap_B", cur, qB.pop_front());
        prevB = cur;
      end
      if (errB === 1'b1) begin
        n_cmp++;
        if (qeB.size() == 0) begin
          n_bad++;
          $display("FAIL error_B: got pulse, required none");
        end else void'(qeB.pop_front());
      end
    end
  end

  task automatic beat(input bit b, input int cx, input int cy, input int x, input int y,
                      input bit last, input bit fs);
    @(negedge clk);
    if (!b) begin
      cxA = 32'(cx); cyA = 32'(cy); vxA = x; vyA = y; lastA = last; fsA = fs; vldA = 1'b1;
    end else begin
      cxB = 32'(cx); cyB = 32'(cy); vxB = x; vyB = y; lastB = last; fsB = fs; vldB = 1'b1;
    end
  endtask

  task automatic clear_in();
    vldA = 0; lastA = 0; fsA = 0;
    vldB = 0; lastB = 0; fsB = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clear_in();
    end
  endtask

  task automatic frame(input bit b);
    @(negedge clk);
    clear_in();
    if (!b) fsA = 1'b1; else fsB = 1'b1;
    @(negedge clk);
    clear_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdyA), 32'd0);
    chk_rec("reset_outputs", snap(1'b0), mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_error", 32'(errA), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdyA), 32'd1);
    prevA = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    prevB = prevA;
    mon_en = 1'b1;

    // Basic triangle, camera (100,50)
    beat(0, 100, 50, 110, 60, 0, 0);
    beat(0, 999, 999, 150, 60, 0, 0);
    beat(0, 999, 999, 130, 90, 1, 0);
    idle(2);
    chk("ready_pending_t1", 32'(rdyA), 32'd0);
    qA.push_back(mk(3, 10, 50, 30, 0, 10, 10, 40, 0));
    frame(0);
    idle(1);
    chk("ready_after_swap_t1", 32'(rdyA), 32'd1);

    // Quad with frame_start coincident with the last accept
    beat(0, 0, 0, 1, 2, 0, 0);
    beat(0, 0, 0, 3, 4, 0, 0);
    beat(0, 0, 0, 5, 6, 0, 0);
    beat(0, 0, 0, 7, 8, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ready_pending_t2", 32'(rdyA), 32'd0);
      clear_in();
    end
    qA.push_back(mk(4, 1, 3, 5, 7, 2, 4, 6, 8));
    frame(0);
    idle(1);

    // Overflow: five beats into a four-slot buffer
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) qeA.push_back(1);
      beat(0, 0, 0, 10 * i, 10 * i, (i == 5), 0);
    end
    idle(2);
    chk("ready_after_overflow", 32'(rdyA), 32'd1);
    frame(0);
    idle(2);

    // Too few vertices
    beat(0, 0, 0, 40, 41, 0, 0);
    qeA.push_back(1);
    beat(0, 0, 0, 42, 43, 1, 0);
    idle(2);
    chk("ready_after_short", 32'(rdyA), 32'd1);
    chk("np_after_short", 32'(npA), 32'd4);
    frame(0);
    idle(2);

    // Reset in the middle of a load, then a fresh triangle
    beat(0, 0, 0, 1, 1, 0, 0);
    beat(0, 0, 0, 2, 2, 0, 0);
    qA.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 32'(rdyA), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", 32'(rdyA), 32'd1);
    beat(0, 10, 20, 11, 21, 0, 0);
    beat(0, 10, 20, 12, 22, 0, 0);
    beat(0, 10, 20, 13, 23, 1, 0);
    idle(2);
    qA.push_back(mk(3, 1, 2, 3, 0, 1, 2, 3, 0));
    frame(0);
    idle(2);

    // Scale 2, camera moves from 0 to 1000 after the first vertex
    beat(1, 0, 0, 3, 4, 0, 0);
    beat(1, 1000, 1000, 5, 6, 0, 0);
    beat(1, 1000, 1000, 7, 8, 1, 0);
    idle(2);
    chk("ready_pending_b", 32'(rdyB), 32'd0);
    qB.push_back(mk(3, 6, 10, 14, 0, 8, 12, 16, 0));
    frame(1);
    idle(3);

    chk("pending_swaps_A", 32'(qA.size()), 32'd0);
    chk("pending_errors_A", 32'(qeA.size()), 32'd0);
    chk("pending_swaps_B", 32'(qB.size()), 32'd0);
    chk("pending_errors_B", 32'(qeB.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/polygon_vertex_loader.md
POLYGON_VERTEX_LOADER -- requirements
Module: polygon_vertex_loader

Interface
REQ-001 SHALL have parameter MAX_NUM_VERTICES, default 4: vertex capacity per polygon; must be at least 3.
REQ-002 SHALL have parameter PIXEL_SCALE, default 1: integer world-to-screen zoom factor.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have these ports, clock and reset first:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- frame_start_in, input, 1: one-cycle pulse at the frame boundary.
- camera_x_in, input, 32: camera world x.
- camera_y_in, input, 32: camera world y.
- vertex_valid_in, input, 1: vertex beat offered.
- vertex_ready_out, output, 1: loader accepts a beat.
- vertex_x_in, input, signed 32: world x.
- vertex_y_in, input, signed 32: world y.
- vertex_last_in, input, 1: final vertex of the polygon.
- xs_out, output, signed 32 [MAX_NUM_VERTICES]: screen x values for the fill stage.
- ys_out, output, signed 32 [MAX_NUM_VERTICES]: screen y values for the fill stage.
- num_points_out, output, $clog2(MAX_NUM_VERTICES)+1: count of valid vertices.
- polygon_valid_out, output, 1: xs/ys/num_points hold a drawable polygon.
- error_out, output, 1: one-cycle pulse when a polygon is rejected.

Function
REQ-005 SHALL accept a beat only in a cycle where vertex_valid_in=1 and vertex_ready_out=1.
REQ-006 SHALL implement states IDLE, LOAD, DRAIN and PENDING.
REQ-007 SHALL hold vertex_ready_out=1 in IDLE, LOAD and DRAIN, and 0 in PENDING.
REQ-008 SHALL, on an accept in IDLE, sample camera_x_in/camera_y_in and use those values for every vertex of that polygon.
REQ-009 SHALL transform each accepted vertex to screen_x=(x-cam_x)*PIXEL_SCALE and screen_y=(y-cam_y)*PIXEL_SCALE.
REQ-010 SHALL compute the transform in signed 32-bit arithmetic, truncate to 32 bits, and not saturate.
REQ-011 SHALL write transformed vertex k (k=0..count-1) into slot k of a write buffer that is separate from the output buffer.
REQ-012 SHALL transition IDLE->LOAD on accepting a non-last beat.
REQ-013 SHALL, on accepting a last beat with total count>=3, enter PENDING in the next cycle.
REQ-014 SHALL, on accepting a last beat with total count<3, pulse error_out the next cycle, discard the write buffer and return to IDLE.
REQ-015 SHALL, on accepting a non-last beat once MAX_NUM_VERTICES vertices are already stored, not write that beat, pulse error_out the next cycle and enter DRAIN.
REQ-016 SHALL, in DRAIN, discard every beat through the last one and then return to IDLE; the output buffer is unchanged.
REQ-017 SHALL, in PENDING when frame_start_in=1, copy the write buffer to xs_out/ys_out, set num_points_out=count and polygon_valid_out=1 the next cycle, and return to IDLE.
REQ-018 SHALL ignore frame_start_in in IDLE, LOAD and DRAIN, including a frame_start_in coincident with the accept of the last beat; that polygon waits for the next frame_start_in.
REQ-019 SHALL keep xs_out/ys_out/num_points_out/polygon_valid_out stable between swaps.
REQ-020 SHALL hold unused output slots (index>=num_points_out) at 0.
REQ-021 SHALL ignore camera changes in the middle of a polygon.

Reset
REQ-022 SHALL, while rst_in=1, force state=IDLE, vertex_ready_out=0, xs_out/ys_out all 0, num_points_out=0, polygon_valid_out=0, error_out=0, and clear the write buffer and count.
REQ-023 SHALL raise vertex_ready_out in the first cycle after rst_in falls.
REQ-024 SHALL discard a partially loaded polygon when reset is asserted in the middle of loading, and SHALL clear the displayed polygon as well.

Structure
REQ-025 SHALL place the state enum typedef and the default MAX_NUM_VERTICES constant in the shared package polygon_pkg.
REQ-026 SHALL implement the world-to-screen arithmetic in the combinational sub-module vertex_transform, which the fill stage reuses.

Verification
REQ-027 The bench SHALL cover: camera (100,50), PIXEL_SCALE=1, vertices (110,60),(150,60),(130,90) with last, then frame_start -> next cycle xs=(10,50,30,0), ys=(10,10,40,0), num_points=3, polygon_valid=1.
REQ-028 The bench SHALL cover: a 4-vertex polygon loaded, with frame_start pulsed coincident with the last accept and again 10 cycles later -> no swap at the first pulse; swap at the second; ready stays 0 between them.
REQ-029 The bench SHALL cover: 5 beats with last on the fifth, MAX=4 -> error_out pulses once after the fifth accept, no swap on the next frame_start, ready returns to 1.
REQ-030 The bench SHALL cover: 2 beats with last -> error_out pulses, state returns to IDLE, outputs unchanged.
REQ-031 The bench SHALL cover: camera changed from 0 to 1000 after the first vertex, PIXEL_SCALE=2, vertices (3,4),(5,6),(7,8) -> xs=(6,10,14), ys=(8,12,16).
REQ-032 The bench SHALL cover: rst_in asserted after 2 of 3 beats -> outputs all 0, polygon_valid=0; a fresh 3-vertex load afterward works normally.
